dual_port_ram_bist: RTL and testbench



---
 rtl/dual_port_ram_bist.sv | 184 ++++++++++++++++++
 tb/tb_dual_port_ram_bist.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_bist.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_ram_bist
// Brief    : Two-pass dual-port write/read-back BIST with collision check.
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_ram_bist #(
  parameter int length   = 4,
  parameter int location = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [$clog2(location)-1:0] fail_addr,
  output logic                        fail_port,
  output logic                        a_rw,
  output logic                        b_rw,
  output logic [$clog2(location)-1:0] a_w_addr,
  output logic [$clog2(location)-1:0] b_w_addr,
  output logic [$clog2(location)-1:0] a_r_addr,
  output logic [$clog2(location)-1:0] b_r_addr,
  output logic [length-1:0]           a_indata,
  output logic [length-1:0]           b_indata,
  input  logic [length-1:0]           a_outdata,
  input  logic [length-1:0]           b_outdata
);

  localparam int AW = $clog2(location);
  localparam logic [AW-1:0] c_last      = AW'(location - 1);
  localparam logic [AW-1:0] c_half_last = AW'(location / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_READ    = 3'd2,
    S_DRAIN   = 3'd3,
    S_COL_WR  = 3'd4,
    S_COL_RD  = 3'd5,
    S_COL_CMP = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_idx;
  logic              r_k;
  logic              r_cmp_en;
  logic [AW-1:0]     r_cmp_addr;
  logic              r_fail;
  logic [AW-1:0]     w_even;
  logic [AW-1:0]     w_chk_addr_a, w_chk_addr_b;
  logic [length-1:0] w_exp_a, w_exp_b;
  logic              w_chk, w_mis_a, w_mis_b;

  // Alternating 1010 pattern, inverted on the second pass, xor'd with the address.
  function automatic logic [length-1:0] exp_word(input logic [AW-1:0] addr, input logic k);
    logic [length-1:0] pat;
    for (int i = 0; i < length; i++) pat[i] = (i % 2 == 1);
    return (k ? ~pat : pat) ^ length'(addr);
  endfunction

  assign w_even = r_idx << 1;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    a_rw        = 1'b0;
    b_rw        = 1'b0;
    a_w_addr    = '0;
    b_w_addr    = '0;
    a_r_addr    = '0;
    b_r_addr    = '0;
    a_indata    = '0;
    b_indata    = '0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_FILL;
      S_FILL: begin
        busy     = 1'b1;
        a_rw     = 1'b1;
        b_rw     = 1'b1;
        a_w_addr = w_even;
        b_w_addr = w_even | AW'(1);
        a_indata = exp_word(w_even, r_k);
        b_indata = exp_word(w_even | AW'(1), r_k);
        if (r_idx == c_half_last) w_state_nxt = S_READ;
      end
      S_READ: begin
        busy     = 1'b1;
        a_r_addr = r_idx;
        b_r_addr = c_last - r_idx;
        if (r_idx == c_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = r_k ? S_COL_WR : S_FILL;
      end
      S_COL_WR: begin
        busy        = 1'b1;
        a_rw        = 1'b1;
        b_rw        = 1'b1;
        a_indata    = '1;
        w_state_nxt = S_COL_RD;
      end
      S_COL_RD: begin
        busy        = 1'b1;
        w_state_nxt = S_COL_CMP;
      end
      S_COL_CMP: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read data arrives one cycle after the address, so checks use last cycle's address.
  always_comb begin
    w_chk        = r_cmp_en;
    w_chk_addr_a = r_cmp_addr;
    w_chk_addr_b = c_last - r_cmp_addr;
    w_exp_a      = exp_word(w_chk_addr_a, r_k);
    w_exp_b      = exp_word(w_chk_addr_b, r_k);
    if (r_state == S_COL_CMP) begin
      w_chk        = 1'b1;
      w_chk_addr_a = '0;
      w_chk_addr_b = '0;
      w_exp_a      = '1;
      w_exp_b      = '1;
    end
    w_mis_a = w_chk && (a_outdata != w_exp_a);
    w_mis_b = w_chk && (b_outdata != w_exp_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_k        <= 1'b0;
      r_cmp_en   <= 1'b0;
      r_cmp_addr <= '0;
      r_fail     <= 1'b0;
      pass       <= 1'b0;
      fail_addr  <= '0;
      fail_port  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmp_en   <= (r_state == S_READ);
      r_cmp_addr <= r_idx;
      case (r_state)
        S_IDLE: if (start) begin
          r_idx     <= '0;
          r_k       <= 1'b0;
          r_fail    <= 1'b0;
          pass      <= 1'b0;
          fail_addr <= '0;
          fail_port <= 1'b0;
        end
        S_FILL:  r_idx <= (r_idx == c_half_last) ? '0 : r_idx + 1'b1;
        S_READ:  r_idx <= (r_idx == c_last) ? '0 : r_idx + 1'b1;
        S_DRAIN: begin
          r_k   <= 1'b1;
          r_idx <= '0;
        end
        default: ;
      endcase
      // First failure is sticky; port A takes priority on a same-cycle double miss.
      if (!r_fail && (w_mis_a || w_mis_b)) begin
        r_fail    <= 1'b1;
        fail_port <= !w_mis_a;
        fail_addr <= w_mis_a ? w_chk_addr_a : w_chk_addr_b;
      end
      if (r_state == S_COL_CMP) pass <= !(r_fail || w_mis_a || w_mis_b);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_ram_bist
// Brief    : Self-checking bench with a faultable dual-port RAM and result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_bist;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       busy, done, pass, fail_port;
  logic [2:0] fail_addr;
  logic       a_rw, b_rw;
  logic [2:0] a_w_addr, b_w_addr, a_r_addr, b_r_addr;
  logic [3:0] a_indata, b_indata, a_outdata, b_outdata;

  int checks   = 0;
  int failures = 0;

  dual_port_ram_bist #(.length(4), .location(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_port(fail_port),
    .a_rw(a_rw), .b_rw(b_rw),
    .a_w_addr(a_w_addr), .b_w_addr(b_w_addr),
    .a_r_addr(a_r_addr), .b_r_addr(b_r_addr),
    .a_indata(a_indata), .b_indata(b_indata),
    .a_outdata(a_outdata), .b_outdata(b_outdata)
  );

  always #5 clk = ~clk;

  // Faultable RAM: optional stuck bit on one word, selectable collision winner.
  logic [3:0] mem [0:7];
  logic       f_en, f_val, b_wins;
  logic [2:0] f_addr;
  int         f_bit;
  logic [21:0] exp_wave [0:28];

  function automatic logic [3:0] fault(input int ad, input logic [3:0] d);
    logic [3:0] mask;
    mask = 4'(1 << f_bit);
    if (f_en && ad == int'(f_addr)) return f_val ? (d | mask) : (d & ~mask);
    return d;
  endfunction

  always @(posedge clk) begin
    a_outdata <= fault(int'(a_r_addr), mem[a_r_addr]);
    b_outdata <= fault(int'(b_r_addr), mem[b_r_addr]);
    if (b_wins) begin
      if (a_rw) mem[a_w_addr] <= a_indata;
      if (b_rw) mem[b_w_addr] <= b_indata;
    end else begin
      if (b_rw) mem[b_w_addr] <= b_indata;
      if (a_rw) mem[a_w_addr] <= a_indata;
    end
  end

  function automatic logic [3:0] expw(input int a, input int k);
    logic [3:0] p;
    p = 4'b1010;
    return (k != 0 ? ~p : p) ^ 4'(a);
  endfunction

  function automatic logic [21:0] pack(input int arw, input int brw, input int aw, input int bw,
                                       input int ar, input int br, input int ai, input int bi);
    return {1'(arw), 1'(brw), 3'(aw), 3'(bw), 3'(ar), 3'(br), 4'(ai), 4'(bi)};
  endfunction

  task automatic build_wave();
    int n;
    n = 0;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        exp_wave[n] = pack(1, 1, 2*j, 2*j+1, 0, 0, int'(expw(2*j, k)), int'(expw(2*j+1, k)));
        n++;
      end
      for (int j = 0; j < 8; j++) begin
        exp_wave[n] = pack(0, 0, 0, 0, j, 7-j, 0, 0);
        n++;
      end
      exp_wave[n] = '0;
      n++;
    end
    exp_wave[n]   = pack(1, 1, 0, 0, 0, 0, 15, 0);
    exp_wave[n+1] = '0;
    exp_wave[n+2] = '0;
  endtask

  // Result predicted from the test algorithm applied to the faulty memory.
  task automatic model(output logic ep, output logic [2:0] ea, output logic efp);
    logic [3:0] m [0:7];
    logic [3:0] da, db;
    logic       fl;
    fl = 1'b0; ea = '0; efp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 8; a++) m[a] = expw(a, k);
      for (int j = 0; j < 8; j++) begin
        da = fault(j, m[j]);
        db = fault(7-j, m[7-j]);
        if (!fl && da !== expw(j, k)) begin
          fl = 1'b1; ea = 3'(j); efp = 1'b0;
        end else if (!fl && db !== expw(7-j, k)) begin
          fl = 1'b1; ea = 3'(7-j); efp = 1'b1;
        end
      end
    end
    m[0] = b_wins ? 4'h0 : 4'hf;
    da = fault(0, m[0]);
    if (!fl && da !== 4'hf) begin
      fl = 1'b1; ea = '0; efp = 1'b0;
    end
    ep = !fl;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {3'b0, busy, done, pass, fail_addr, fail_port, a_rw, b_rw, a_w_addr, b_w_addr,
            a_r_addr, b_r_addr, a_indata, b_indata};
  endfunction

  task automatic run_test(input string tag, input bit rand_start);
    logic        ep, efp;
    logic [2:0]  ea;
    logic [21:0] obs;
    int          n, wave_bad;
    model(ep, ea, efp);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    wave_bad = 0;
    while (busy === 1'b1 && n < 100) begin
      obs = {a_rw, b_rw, a_w_addr, b_w_addr, a_r_addr, b_r_addr, a_indata, b_indata};
      if (n < 29 && wave_bad == 0 && obs !== exp_wave[n]) wave_bad = n + 1;
      n++;
      if (rand_start) start = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, n, 29);
    check({tag, "_wave_first_bad_cycle"}, wave_bad, 0);
    check({tag, "_done"}, {31'b0, done}, 1);
    check({tag, "_pass"}, {31'b0, pass}, {31'b0, ep});
    check({tag, "_fail_addr"}, {29'b0, fail_addr}, {29'b0, ea});
    check({tag, "_fail_port"}, {31'b0, fail_port}, {31'b0, efp});
    step();
    check({tag, "_idle_after"}, {30'b0, busy, done}, 0);
    check({tag, "_result_held"}, {27'b0, pass, fail_addr, fail_port}, {27'b0, ep, ea, efp});
  endtask

  initial begin
    int ndone, first, prev, bad_int, bad_pass, guard;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    rst = 1'b1; start = 1'b0;
    f_en = 1'b0; f_addr = '0; f_bit = 0; f_val = 1'b0; b_wins = 1'b0;
    build_wave();
    step(); step();
    rst = 1'b0;
    check("reset_outputs", all_outs(), 0);
    step();
    check("idle_outputs", all_outs(), 0);

    run_test("clean", 1'b0);

    f_en = 1'b1; f_addr = 3'd5; f_bit = 0; f_val = 1'b0;
    run_test("stuck5", 1'b0);
    f_en = 1'b0;

    b_wins = 1'b1;
    run_test("bwins", 1'b0);
    b_wins = 1'b0;

    // Abort during READ of the second pass.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun_reset_outputs", all_outs(), 0);
    run_test("after_reset", 1'b0);

    for (int r = 0; r < 6; r++) begin
      f_en   = 1'($urandom_range(0, 1));
      f_addr = 3'($urandom_range(0, 7));
      f_bit  = int'($urandom_range(0, 3));
      f_val  = 1'($urandom_range(0, 1));
      b_wins = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) step();
      run_test($sformatf("rand%0d", r), 1'b1);
    end
    f_en = 1'b0; b_wins = 1'b0;

    // Continuous start: back-to-back runs.
    ndone = 0; first = 0; prev = 0; bad_int = 0; bad_pass = 0;
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) first = c;
        else if (c - prev != 31) bad_int++;
        prev = c;
        if (pass !== 1'b1) bad_pass++;
      end
    end
    start = 1'b0;
    check("held_done_count", ndone, 3);
    check("held_first_done", first, 30);
    check("held_bad_intervals", bad_int, 0);
    check("held_bad_pass", bad_pass, 0);
    guard = 0;
    while (done !== 1'b1 && guard < 60) begin
      step();
      guard++;
    end
    check("held_final_done_seen", {31'b0, done}, 1);
    step();
    check("held_final_idle", {30'b0, busy, done}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
